voice_mix_scheduler: RTL and testbench
======================================

Name: voice_mix_scheduler

Overview:
Time-multiplexes one shared sine ROM (4096 x 16) and one phase-add datapath across NUM_VOICES independent tone voices. On each accepted sample strobe it steps every voice's 32-bit phase accumulator, reads each voice's sample from the ROM in turn, and produces one averaged 16-bit offset-binary mix for the downstream PDM modulator. It sits between the song/tempo logic, which writes per-voice step sizes, and the PDM accumulator, which consumes mix_sample on mix_valid.

Parameters:
NUM_VOICES, 4, voice count; power of two, 2..8
PHASE_W, 32, phase accumulator / step width
ADDR_W, 12, ROM address width = phase[PHASE_W-1 -: ADDR_W]
SAMPLE_W, 16, ROM and mix sample width, unsigned offset-binary, 0x8000 = silence
VW, clog2(NUM_VOICES), derived; voice index width

Ports:
clk  in  1  system clock (24 MHz PLL output)
rst_n  in  1  asynchronous active-low reset
sample_ce  in  1  single-cycle sample strobe
voice_en  in  NUM_VOICES  per-voice enable, latched at frame start
cfg_we  in  1  step register write strobe
cfg_voice  in  VW  voice index for cfg_we
cfg_step  in  PHASE_W  phase increment per frame
rom_addr  out  ADDR_W  registered ROM address
rom_data  in  SAMPLE_W  ROM read data, valid exactly 1 cycle after rom_addr
mix_sample  out  SAMPLE_W  averaged mix, held between updates
mix_valid  out  1  one-cycle pulse when mix_sample updates
busy  out  1  frame in progress
overrun  out  1  sticky: a strobe was dropped
overrun_clr  in  1  clears overrun

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: all phases 0, all step registers 0, rom_addr 0, mix_sample 0x8000, mix_valid 0, busy 0, overrun 0, FSM IDLE.
- Step registers: cfg_we writes step[cfg_voice] <= cfg_step at any time. A running frame always uses latched copies.
- FSM states: IDLE, ISSUE, DRAIN, OUT.
- IDLE: sample_ce=1 accepts the frame. Latch all steps and voice_en into frame copies, clear sum, set busy, go to ISSUE with voice counter k=0.
- Write and acceptance in the same cycle: the frame latches the OLD step. The new step applies from the next frame.
- ISSUE (NUM_VOICES cycles, k=0..N-1): rom_addr <= phase[k][31:20], using the pre-update phase. If enabled, phase[k] <= phase[k] + step_latched[k] mod 2^32; if disabled, phase[k] is held.
- Data capture: rom_data for voice k is sampled on the cycle after its address. A disabled voice contributes 0x8000 in place of rom_data. Sum width is SAMPLE_W+VW with no overflow possible.
- After k=N-1, go to DRAIN for one cycle to capture the last sample, then OUT.
- OUT: mix_sample <= sum >> VW, mix_valid=1 for one cycle, busy=0, return to IDLE.
- Timing: if sample_ce is high at cycle t0, rom_addr presents voice k during t0+1+k. mix_valid is high during t0+N+3. busy is high during t0+1..t0+N+2.
- Required strobe period is >= N+4 cycles (8 for N=4; top level divides 24 MHz by 8).
- sample_ce while not IDLE, including the OUT cycle: the strobe is dropped, overrun <= 1, and the current frame is unaffected.
- overrun_clr and a new drop in the same cycle: set wins.
- Reset mid-frame: immediate abort to the reset values; no mix_valid is produced.
- rom_addr holds its last value when idle.

Test Plan:
- Reset check: release rst_n, no strobes -> mix_sample=0x8000, mix_valid=0, busy=0, overrun=0, rom_addr=0.
- Single voice, ROM model data=addr*16: step[0]=0x0010_0000, voice_en=0001, strobe period 8 -> frame1 mix=0x6000; frame2 rom_addr for v0=1, mix=0x6004; mix_valid exactly 7 cycles after each strobe.
- Four voices with steps 0x00100000, 0x00200000, 0x00300000, 0xFFF00000, all enabled -> frame2 addresses 1,2,3,0xFFF in order on consecutive cycles; frame3 voice3 address 0xFFE (wrap-around).
- Overrun: strobes at t=0 and t=6 -> one mix_valid, overrun=1 from t=7; overrun_clr pulse -> overrun=0; a simultaneous drop and clear -> overrun stays 1.
- Config race: cfg_we step[0]=0x00200000 in the acceptance cycle of a frame with old step 0x00100000 -> that frame advances phase by 0x00100000; the next frame advances it by 0x00200000.
- Reset mid-ISSUE at t0+2 -> no mix_valid, busy=0, all phases 0; the next frame reads address 0 for every voice.

Source files
------------

// File: rtl/voice_mix_scheduler.sv
// Shares one synchronous sine ROM and one phase adder across NUM_VOICES tone
// voices. Each accepted sample strobe steps every voice's phase, reads each
// voice's sample in turn and emits the averaged offset-binary mix.
module voice_mix_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int ADDR_W     = 12,
  parameter int SAMPLE_W   = 16,
  localparam int VW        = $clog2(NUM_VOICES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_ce,
  input  logic [NUM_VOICES-1:0] voice_en,
  input  logic                cfg_we,
  input  logic [VW-1:0]       cfg_voice,
  input  logic [PHASE_W-1:0]  cfg_step,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic [SAMPLE_W-1:0] mix_sample,
  output logic                mix_valid,
  output logic                busy,
  output logic                overrun,
  input  logic                overrun_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  localparam logic [VW-1:0]       LAST = VW'(NUM_VOICES - 1);
  localparam logic [SAMPLE_W-1:0] MID  = {1'b1, {(SAMPLE_W-1){1'b0}}};

  state_t                              state;
  logic [VW-1:0]                       k;
  logic [VW-1:0]                       nxt;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]  phase;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]  step;
  logic [NUM_VOICES-1:0][PHASE_W-1:0]  step_l;
  logic [NUM_VOICES-1:0]               en_l;
  logic [SAMPLE_W+VW-1:0]              sum;

  logic                cap;
  logic [VW-1:0]       cap_idx;
  logic [SAMPLE_W-1:0] cap_data;

  // Step registers: writable any time; a frame only ever sees its latched copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++)
        if (cfg_we && cfg_voice == VW'(v)) step[v] <= cfg_step;
    end
  end

  // ROM data lags its address by one cycle, so the voice captured is one
  // behind the voice being issued; DRAIN picks up the last voice.
  always_comb begin
    nxt      = k + VW'(1);
    cap      = (state == ISSUE && k != '0) || (state == DRAIN);
    cap_idx  = (state == DRAIN) ? LAST : k - VW'(1);
    cap_data = en_l[cap_idx] ? rom_data : MID;
  end

  // Frame sequencer. Voice 0's address is issued on the accept edge so that
  // voice k is on rom_addr during the k-th cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      phase      <= '0;
      step_l     <= '0;
      en_l       <= '0;
      sum        <= '0;
      rom_addr   <= '0;
      mix_sample <= MID;
      mix_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mix_valid <= 1'b0;

      // A strobe outside IDLE is dropped; a new drop beats a clear.
      if (sample_ce && state != IDLE) overrun <= 1'b1;
      else if (overrun_clr)           overrun <= 1'b0;

      if (cap) sum <= sum + {{VW{1'b0}}, cap_data};

      case (state)
        IDLE: begin
          if (sample_ce) begin
            step_l   <= step;
            en_l     <= voice_en;
            sum      <= '0;
            busy     <= 1'b1;
            k        <= '0;
            state    <= ISSUE;
            rom_addr <= phase[0][PHASE_W-1 -: ADDR_W];
            if (voice_en[0]) phase[0] <= phase[0] + step[0];
          end
        end
        ISSUE: begin
          if (k == LAST) begin
            state <= DRAIN;
          end else begin
            k        <= nxt;
            rom_addr <= phase[nxt][PHASE_W-1 -: ADDR_W];
            if (en_l[nxt]) phase[nxt] <= phase[nxt] + step_l[nxt];
          end
        end
        DRAIN: state <= OUT;
        OUT: begin
          mix_sample <= SAMPLE_W'(sum >> VW);
          mix_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Bench for voice_mix_scheduler: directed scenarios followed by randomized
// frames, all checked against a frame-level reference model.
module tb_voice_mix_scheduler;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_ce;
  logic [N-1:0] voice_en;
  logic        cfg_we;
  logic [1:0]  cfg_voice;
  logic [31:0] cfg_step;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] mix_sample;
  logic        mix_valid;
  logic        busy;
  logic        overrun;
  logic        overrun_clr;

  voice_mix_scheduler #(.NUM_VOICES(N)) dut (
    .clk(clk), .rst_n(rst_n), .sample_ce(sample_ce), .voice_en(voice_en),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_step(cfg_step),
    .rom_addr(rom_addr), .rom_data(rom_data), .mix_sample(mix_sample),
    .mix_valid(mix_valid), .busy(busy), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  // ROM model: either data = addr*16 or a random table, one-cycle latency.
  bit          rom_mode = 1'b1;
  logic [15:0] rom_tbl [4096];

  function automatic logic [15:0] rom_val(input logic [11:0] a);
    return rom_mode ? {a, 4'h0} : rom_tbl[a];
  endfunction

  always @(posedge clk) rom_data <= rom_val(rom_addr);

  // Reference model state.
  logic [31:0] mphase [N];
  logic [31:0] mstep  [N];
  bit          m_ovr;
  logic [15:0] m_mix;
  logic [11:0] last_addr [N];
  logic [15:0] last_mix;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin mphase[v] = '0; mstep[v] = '0; end
    m_ovr = 1'b0;
    m_mix = 16'h8000;
  endtask

  task automatic write_step(input logic [1:0] v, input logic [31:0] s);
    cfg_we = 1'b1; cfg_voice = v; cfg_step = s;
    @(negedge clk);
    cfg_we = 1'b0;
    mstep[v] = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_mix_valid", mix_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
      @(negedge clk);
    end
  endtask

  // One frame: strobe in the current cycle (t0), check every cycle through
  // t0+7, return at t0+8 (strobe period 8). Optional extra strobe / clear at
  // cycle offsets and a step write in the acceptance cycle.
  task automatic run_frame(input logic [N-1:0] en, input int ce_off, input int clr_off,
                           input bit cfg_now, input logic [1:0] cfg_v, input logic [31:0] cfg_s);
    logic [11:0] ea [N];
    int          s;
    logic [15:0] emix;
    s = 0;
    for (int v = 0; v < N; v++) begin
      ea[v] = mphase[v][31:20];
      s += en[v] ? int'(rom_val(ea[v])) : 32'h8000;
    end
    emix = 16'(s / N);
    for (int v = 0; v < N; v++) if (en[v]) mphase[v] = mphase[v] + mstep[v];

    voice_en  = en;
    sample_ce = 1'b1;
    if (cfg_now) begin
      cfg_we = 1'b1; cfg_voice = cfg_v; cfg_step = cfg_s;
      mstep[cfg_v] = cfg_s;
    end
    @(negedge clk);
    sample_ce = 1'b0;
    cfg_we    = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      chk("busy", busy, c <= N + 2);
      chk("mix_valid", mix_valid, c == N + 3);
      chk("overrun", overrun, m_ovr);
      chk("mix_sample", mix_sample, (c == N + 3) ? emix : m_mix);
      if (c <= N) begin
        chk("rom_addr", rom_addr, ea[c-1]);
        last_addr[c-1] = rom_addr;
      end
      if (c == N + 3) begin
        m_mix    = emix;
        last_mix = mix_sample;
      end
      sample_ce   = (c == ce_off);
      overrun_clr = (c == clr_off);
      if (c == ce_off) m_ovr = 1'b1;
      else if (c == clr_off) m_ovr = 1'b0;
      @(negedge clk);
    end
    sample_ce   = 1'b0;
    overrun_clr = 1'b0;
  endtask

  initial begin
    logic [11:0] a0;
    rst_n = 1'b0; sample_ce = 1'b0; voice_en = '0; cfg_we = 1'b0;
    cfg_voice = '0; cfg_step = '0; overrun_clr = 1'b0;
    for (int i = 0; i < 4096; i++) rom_tbl[i] = 16'($urandom);
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("rst_mix_sample", mix_sample, 16'h8000);
    chk("rst_mix_valid", mix_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_rom_addr", rom_addr, 12'h000);

    // Single voice, data = addr*16
    write_step(2'd0, 32'h0010_0000);
    run_frame(4'b0001, 0, 0, 1'b0, 2'd0, 32'h0);
    chk("single_f1_mix", last_mix, 16'h6000);
    run_frame(4'b0001, 0, 0, 1'b0, 2'd0, 32'h0);
    chk("single_f2_addr", last_addr[0], 12'h001);
    chk("single_f2_mix", last_mix, 16'h6004);

    // Four voices, wrap-around on voice 3
    do_reset();
    write_step(2'd0, 32'h0010_0000);
    write_step(2'd1, 32'h0020_0000);
    write_step(2'd2, 32'h0030_0000);
    write_step(2'd3, 32'hFFF0_0000);
    run_frame(4'b1111, 0, 0, 1'b0, 2'd0, 32'h0);
    run_frame(4'b1111, 0, 0, 1'b0, 2'd0, 32'h0);
    chk("four_f2_a0", last_addr[0], 12'h001);
    chk("four_f2_a1", last_addr[1], 12'h002);
    chk("four_f2_a2", last_addr[2], 12'h003);
    chk("four_f2_a3", last_addr[3], 12'hFFF);
    run_frame(4'b1111, 0, 0, 1'b0, 2'd0, 32'h0);
    chk("four_f3_a3_wrap", last_addr[3], 12'hFFE);

    // Overrun: drop at t0+6 (OUT cycle), clear, then drop+clear together
    run_frame(4'b1111, 6, 0, 1'b0, 2'd0, 32'h0);
    idle(1);
    chk("ovr_set", overrun, 1'b1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    m_ovr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);
    run_frame(4'b1111, 3, 3, 1'b0, 2'd0, 32'h0);
    chk("ovr_set_wins", overrun, 1'b1);

    // Config race: write in acceptance cycle applies from the next frame
    a0 = mphase[0][31:20];
    run_frame(4'b1111, 0, 0, 1'b1, 2'd0, 32'h0020_0000);
    chk("race_f1_a0", last_addr[0], a0);
    run_frame(4'b1111, 0, 0, 1'b0, 2'd0, 32'h0);
    chk("race_f2_a0", last_addr[0], 12'(a0 + 12'd1));
    run_frame(4'b1111, 0, 0, 1'b0, 2'd0, 32'h0);
    chk("race_f3_a0", last_addr[0], 12'(a0 + 12'd3));

    // Reset mid-ISSUE at t0+2
    voice_en  = 4'b1111;
    sample_ce = 1'b1;
    @(negedge clk);
    sample_ce = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mix_valid", mix_valid, 1'b0);
    chk("midrst_rom_addr", rom_addr, 12'h000);
    chk("midrst_mix_sample", mix_sample, 16'h8000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(8);
    run_frame(4'b1111, 0, 0, 1'b0, 2'd0, 32'h0);
    for (int v = 0; v < N; v++) chk("midrst_next_addr", last_addr[v], 12'h000);

    // Randomized frames against the model with a random ROM
    rom_mode = 1'b0;
    for (int v = 0; v < N; v++) write_step(2'(v), $urandom);
    for (int i = 0; i < 40; i++) begin
      int ce_off, clr_off;
      ce_off  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + 2)) : 0;
      clr_off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + 3)) : 0;
      run_frame(4'($urandom), ce_off, clr_off, 1'($urandom_range(0, 1)),
                2'($urandom), $urandom);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
